// File: rtl/psg_multichannel.sv
// Multichannel programmable sound generator: N square-wave tones, one shared LFSR noise
// source and envelope, log-volume per channel and a saturating mixer behind an AY-style bus.
module psg_multichannel #(
  parameter int NUM_CHANNELS = 3,
  parameter int ADDR_BITS    = 5,
  parameter int CHIP_MASK    = 0,
  parameter int CHANNEL_BITS = 8,
  parameter int MASTER_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_in,
  input  logic                   bdir,
  input  logic                   bc1,
  output logic [7:0]             data_out,
  output logic                   data_oe,
  output logic [MASTER_BITS-1:0] master_out
);
  localparam int N         = NUM_CHANNELS;
  localparam int NADDR     = 1 << ADDR_BITS;
  localparam int A_NOISE   = 2 * N;
  localparam int A_MIX     = 2 * N + 1;
  localparam int A_AMP     = 2 * N + 2;
  localparam int A_EFINE   = 3 * N + 2;
  localparam int A_ECOARSE = 3 * N + 3;
  localparam int A_SHAPE   = 3 * N + 4;
  localparam int SUM_BITS  = CHANNEL_BITS + 2;
  localparam int MAX_OUT   = (1 << MASTER_BITS) - 1;
  localparam logic [7-ADDR_BITS:0] CHIP_VAL = CHIP_MASK[7-ADDR_BITS:0];

  // Implemented bits per address; unimplemented addresses store nothing and read as 0.
  function automatic logic [7:0] reg_mask(input int a);
    logic [7:0] m;
    m = 8'h00;
    if (a < A_NOISE)       m = a[0] ? 8'h0F : 8'hFF;
    else if (a == A_NOISE) m = 8'h1F;
    else if (a == A_MIX)   m = 8'((16'd1 << (2 * N)) - 16'd1);
    else if (a < A_EFINE)  m = 8'h1F;
    else if (a < A_SHAPE)  m = 8'hFF;
    else if (a == A_SHAPE) m = 8'h0F;
    else                   m = 8'h00;
    return m;
  endfunction

  // Full scale times 2^(-(15-a)/2); odd exponents use a 32-bit fixed-point 1/sqrt(2).
  // Level 1 is treated as silent, like level 0.
  function automatic logic [CHANNEL_BITS-1:0] lut_val(input int a);
    logic [63:0] full;
    logic [63:0] v;
    int          k;
    full = (64'd1 << CHANNEL_BITS) - 64'd1;
    k    = 15 - a;
    if (a < 2)     v = 64'd0;
    else if (k[0]) v = (full * 64'd3037000499) >> (32 + k / 2);
    else           v = full >> (k / 2);
    return CHANNEL_BITS'(v);
  endfunction

  logic [7:0]              r_regs [NADDR];
  logic [7:0]              w_mask [NADDR];
  logic [CHANNEL_BITS-1:0] w_lut  [16];
  logic                    r_active;
  logic [ADDR_BITS-1:0]    r_addr;
  logic                    w_latch, w_write, w_read, w_chip_ok, w_shape_wr;

  for (genvar g = 0; g < NADDR; g++) begin : g_mask
    assign w_mask[g] = reg_mask(g);
  end
  for (genvar g = 0; g < 16; g++) begin : g_lut
    assign w_lut[g] = lut_val(g);
  end

  assign w_latch    = bdir & bc1;
  assign w_write    = bdir & ~bc1 & r_active;
  assign w_read     = ~bdir & bc1 & r_active;
  assign w_chip_ok  = (data_in[7:ADDR_BITS] == CHIP_VAL);
  assign w_shape_wr = w_write & (r_addr == ADDR_BITS'(A_SHAPE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_addr   <= '0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      for (int k = 0; k < NADDR; k++) r_regs[k] <= 8'h00;
    end else begin
      data_oe <= w_read;
      if (w_latch) begin
        r_active <= w_chip_ok;
        if (w_chip_ok) r_addr <= data_in[ADDR_BITS-1:0];
      end
      if (w_write) r_regs[r_addr] <= data_in & w_mask[r_addr];
      if (w_read)  data_out <= r_regs[r_addr];
    end
  end

  logic [11:0]      w_tone_per [N];
  logic [11:0]      w_tone_lim [N];
  logic [4:0]       w_amp      [N];
  logic [4:0]       w_noise_lim;
  logic [2*N-1:0]   w_mixer;
  logic [15:0]      w_env_per, w_env_lim;
  logic [3:0]       w_shape;

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign w_tone_per[g] = {r_regs[2*g+1][3:0], r_regs[2*g]};
    assign w_tone_lim[g] = (w_tone_per[g] == 12'd0) ? 12'd0 : w_tone_per[g] - 12'd1;
    assign w_amp[g]      = r_regs[A_AMP+g][4:0];
  end
  assign w_noise_lim = (r_regs[A_NOISE][4:0] == 5'd0) ? 5'd0 : r_regs[A_NOISE][4:0] - 5'd1;
  assign w_mixer     = r_regs[A_MIX][2*N-1:0];
  assign w_env_per   = {r_regs[A_ECOARSE], r_regs[A_EFINE]};
  assign w_env_lim   = (w_env_per == 16'd0) ? 16'd0 : w_env_per - 16'd1;
  assign w_shape     = r_regs[A_SHAPE][3:0];

  logic [7:0] r_pre;
  logic       w_tick16, w_tick256;
  assign w_tick16  = (r_pre[3:0] == 4'hF);
  assign w_tick256 = (r_pre == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pre <= 8'h00;
    else       r_pre <= r_pre + 8'd1;
  end

  logic [11:0] r_tone_cnt [N];
  logic [N-1:0] r_tone;
  logic [4:0]  r_noise_cnt;
  logic [16:0] r_lfsr;
  logic        w_noise;
  assign w_noise = r_lfsr[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) r_tone_cnt[k] <= 12'd0;
      r_tone      <= '0;
      r_noise_cnt <= 5'd0;
      r_lfsr      <= 17'h1;
    end else if (w_tick16) begin
      for (int k = 0; k < N; k++) begin
        if (r_tone_cnt[k] >= w_tone_lim[k]) begin
          r_tone_cnt[k] <= 12'd0;
          r_tone[k]     <= ~r_tone[k];
        end else begin
          r_tone_cnt[k] <= r_tone_cnt[k] + 12'd1;
        end
      end
      if (r_noise_cnt >= w_noise_lim) begin
        r_noise_cnt <= 5'd0;
        r_lfsr      <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
      end else begin
        r_noise_cnt <= r_noise_cnt + 5'd1;
      end
    end
  end

  // Shape bits: [3] continue, [2] attack, [1] alternate, [0] hold.
  logic [15:0] r_env_cnt;
  logic [3:0]  r_env_step, r_env_hval, w_env_raw, w_env;
  logic        r_env_hold, r_env_inv;
  assign w_env_raw = (w_shape[2] ^ r_env_inv) ? r_env_step : 4'hF - r_env_step;
  assign w_env     = r_env_hold ? r_env_hval : w_env_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_env_cnt  <= 16'd0;
      r_env_step <= 4'd0;
      r_env_hval <= 4'd0;
      r_env_hold <= 1'b0;
      r_env_inv  <= 1'b0;
    end else if (w_shape_wr) begin
      r_env_cnt  <= 16'd0;
      r_env_step <= 4'd0;
      r_env_hold <= 1'b0;
      r_env_inv  <= 1'b0;
    end else if (w_tick256 && !r_env_hold) begin
      if (r_env_cnt >= w_env_lim) begin
        r_env_cnt <= 16'd0;
        if (r_env_step == 4'hF) begin
          if (!w_shape[3]) begin
            r_env_hold <= 1'b1;
            r_env_hval <= 4'd0;
          end else if (w_shape[0]) begin
            r_env_hold <= 1'b1;
            r_env_hval <= w_shape[1] ? ~w_env_raw : w_env_raw;
          end else begin
            r_env_step <= 4'd0;
            if (w_shape[1]) r_env_inv <= ~r_env_inv;
          end
        end else begin
          r_env_step <= r_env_step + 4'd1;
        end
      end else begin
        r_env_cnt <= r_env_cnt + 16'd1;
      end
    end
  end

  logic [SUM_BITS-1:0] w_sum;
  logic [3:0]          w_lvl;

  always_comb begin
    w_sum = '0;
    w_lvl = 4'h0;
    for (int k = 0; k < N; k++) begin
      w_lvl = w_amp[k][4] ? w_env : w_amp[k][3:0];
      if ((r_tone[k] | w_mixer[k]) & (w_noise | w_mixer[N+k]))
        w_sum = w_sum + SUM_BITS'(w_lut[w_lvl]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      master_out <= '0;
    else if (32'(w_sum) > MAX_OUT)  master_out <= MASTER_BITS'(MAX_OUT);
    else                            master_out <= MASTER_BITS'(w_sum);
  end

endmodule

// File: tb/tb_psg_multichannel.sv
// Directed and randomized bench for psg_multichannel against a cycle-level reference model
// built from the register map and timing rules (N=3 main instance, N=4 for mixer saturation).
module tb_psg_multichannel;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       bdir = 1'b0, bc1 = 1'b0;
  logic [7:0] data_out, data_out4, master_out, master_out4;
  logic       data_oe, data_oe4;

  psg_multichannel #(.NUM_CHANNELS(3)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .bdir(bdir), .bc1(bc1),
    .data_out(data_out), .data_oe(data_oe), .master_out(master_out));

  psg_multichannel #(.NUM_CHANNELS(4)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .bdir(bdir), .bc1(bc1),
    .data_out(data_out4), .data_oe(data_oe4), .master_out(master_out4));

  always #5 clk = ~clk;

  localparam int N = 3;
  int n_tests = 0, n_fail = 0;
  int lut [16] = '{0, 0, 2, 3, 5, 7, 11, 15, 22, 31, 45, 63, 90, 127, 180, 255};

  int          m_active, m_addr, m_dout, m_doe, m_pre, m_master;
  int          m_regs [32];
  int          m_tcnt [N];
  int          m_tone [N];
  int          m_ncnt, m_ecnt, m_estep, m_esweep;
  logic [16:0] m_lfsr;
  int          trans, prev, drops, a, v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Implemented bits of each N=3 register (AY R0..R13 layout)
  function automatic int fld_mask(input int adr);
    if (adr < 6)   return (adr % 2 == 1) ? 15 : 255;
    if (adr == 6)  return 31;
    if (adr == 7)  return 63;
    if (adr <= 10) return 31;
    if (adr <= 12) return 255;
    if (adr == 13) return 15;
    return 0;
  endfunction

  function automatic bit env_frozen();
    int shp = m_regs[13];
    return (m_esweep > 0) && (((shp >> 3) & 1) == 0 || (shp & 1) == 1);
  endfunction

  // Envelope value from completed sweep count and step within the sweep
  function automatic int env_out();
    int shp  = m_regs[13];
    int att  = (shp >> 2) & 1;
    int alt  = (shp >> 1) & 1;
    int up;
    if (m_esweep > 0 && ((shp >> 3) & 1) == 0) return 0;
    if (m_esweep > 0 && (shp & 1) == 1) return (att ^ alt) ? 15 : 0;
    up = att ^ (alt & (m_esweep % 2));
    return up ? m_estep : 15 - m_estep;
  endfunction

  task automatic model_init();
    m_active = 0; m_addr = 0; m_dout = 0; m_doe = 0; m_pre = 0; m_master = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int i = 0; i < N; i++) begin m_tcnt[i] = 0; m_tone[i] = 0; end
    m_ncnt = 0; m_ecnt = 0; m_estep = 0; m_esweep = 0; m_lfsr = 17'h1;
  endtask

  task automatic model_step();
    int sum, lvl, per, lim, mix;
    bit lt, wr, rd;
    mix = m_regs[7];
    sum = 0;
    for (int i = 0; i < N; i++) begin
      lvl = ((m_regs[8+i] & 16) != 0) ? env_out() : (m_regs[8+i] & 15);
      if ((m_tone[i] | ((mix >> i) & 1)) != 0 && (int'(m_lfsr[0]) | ((mix >> (N + i)) & 1)) != 0)
        sum += lut[lvl];
    end
    lt = bdir && bc1;
    wr = bdir && !bc1 && (m_active != 0);
    rd = !bdir && bc1 && (m_active != 0);
    if (m_pre % 16 == 15) begin
      for (int i = 0; i < N; i++) begin
        per = m_regs[2*i] + 256 * m_regs[2*i+1];
        lim = (per == 0) ? 0 : per - 1;
        if (m_tcnt[i] >= lim) begin m_tcnt[i] = 0; m_tone[i] ^= 1; end
        else m_tcnt[i]++;
      end
      lim = (m_regs[6] == 0) ? 0 : m_regs[6] - 1;
      if (m_ncnt >= lim) begin m_ncnt = 0; m_lfsr = {m_lfsr[0] ^ m_lfsr[3], m_lfsr[16:1]}; end
      else m_ncnt++;
    end
    if (wr && m_addr == 13) begin
      m_ecnt = 0; m_estep = 0; m_esweep = 0;
    end else if (m_pre == 255 && !env_frozen()) begin
      per = m_regs[11] + 256 * m_regs[12];
      lim = (per == 0) ? 0 : per - 1;
      if (m_ecnt >= lim) begin
        m_ecnt = 0;
        if (m_estep == 15) begin m_estep = 0; m_esweep++; end
        else m_estep++;
      end else m_ecnt++;
    end
    m_doe = rd ? 1 : 0;
    if (rd) m_dout = m_regs[m_addr];
    if (wr) m_regs[m_addr] = int'(data_in) & fld_mask(m_addr);
    if (lt) begin
      if (data_in[7:5] == 3'd0) begin m_active = 1; m_addr = int'(data_in[4:0]); end
      else m_active = 0;
    end
    m_master = (sum > 255) ? 255 : sum;
    m_pre = (m_pre + 1) % 256;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    chk("master_out", 32'(master_out), 32'(m_master));
    chk("data_oe", 32'(data_oe), 32'(m_doe));
    if (m_doe != 0) chk("data_out", 32'(data_out), 32'(m_dout));
  endtask

  task automatic idle(input int n);
    data_in = 8'h00; bdir = 1'b0; bc1 = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic latch(input int adr);
    data_in = 8'(adr); bdir = 1'b1; bc1 = 1'b1; cyc();
  endtask

  task automatic wr_reg(input int adr, input int val);
    latch(adr);
    data_in = 8'(val); bdir = 1'b1; bc1 = 1'b0; cyc();
    idle(1);
  endtask

  task automatic rd_reg(input int adr, input int exp);
    latch(adr);
    bdir = 1'b0; bc1 = 1'b1; cyc();
    chk("rd_oe", 32'(data_oe), 32'd1);
    chk("rd_data", 32'(data_out), 32'(exp));
    idle(1);
    chk("rd_oe_drop", 32'(data_oe), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; data_in = 8'h00; bdir = 1'b0; bc1 = 1'b0;
    model_init();
    @(posedge clk); #1;
    chk("rst_master", 32'(master_out), 32'd0);
    chk("rst_oe", 32'(data_oe), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_oe4", 32'(data_oe4), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    idle(40);

    // Read-back, chip-select mismatch and inactive read
    wr_reg(0, 8'h55);
    rd_reg(0, 8'h55);
    latch(8'h21);
    data_in = 8'hAA; bdir = 1'b1; bc1 = 1'b0; cyc();
    bdir = 1'b0; bc1 = 1'b1; cyc();
    chk("inactive_rd_oe", 32'(data_oe), 32'd0);
    idle(1);
    rd_reg(0, 8'h55);

    // Implemented-bit masking and out-of-map address
    wr_reg(6, 8'hFF);
    rd_reg(6, 8'h1F);
    wr_reg(14, 8'hFF);
    rd_reg(14, 8'h00);
    wr_reg(1, 8'hFF);
    rd_reg(1, 8'h0F);
    wr_reg(6, 0);

    // Tone 0 at period 1: toggles every 16 clocks, output swings 255/0
    wr_reg(0, 1); wr_reg(1, 0); wr_reg(7, 8'h3E); wr_reg(8, 8'h0F);
    trans = 0; prev = int'(master_out);
    for (int i = 0; i < 160; i++) begin
      idle(1);
      if (int'(master_out) != prev) trans++;
      prev = int'(master_out);
    end
    chk("tone_toggles", 32'(trans), 32'd10);

    // Envelope ramp (attack+continue+hold), hold at full scale, restart on rewrite
    wr_reg(7, 8'h3F); wr_reg(8, 8'h10); wr_reg(11, 1); wr_reg(12, 0);
    wr_reg(13, 8'h0D);
    chk("env_start", 32'(master_out), 32'd0);
    drops = 0; prev = 0;
    for (int i = 0; i < 16 * 256 + 300; i++) begin
      idle(1);
      if (int'(master_out) < prev) drops++;
      prev = int'(master_out);
    end
    chk("env_monotonic", 32'(drops), 32'd0);
    chk("env_hold", 32'(master_out), 32'd255);
    idle(600);
    chk("env_still_held", 32'(master_out), 32'd255);
    wr_reg(13, 8'h0D);
    chk("env_restart", 32'(master_out), 32'd0);

    // N=4 instance: all four channels gated on, amplitude 15 saturates
    wr_reg(9, 8'hFF);
    for (int i = 10; i < 14; i++) wr_reg(i, 8'h0F);
    idle(2);
    chk("sat4_full", 32'(master_out4), 32'd255);
    for (int i = 10; i < 14; i++) wr_reg(i, 8'h0A);
    idle(2);
    chk("sum4_level10", 32'(master_out4), 32'd180);
    wr_reg(13, 8'h0E);
    idle(2);
    chk("sat4_mixed", 32'(master_out4), 32'd255);

    // Randomized register traffic against the model
    do_reset();
    for (int it = 0; it < 70; it++) begin
      a = int'($urandom_range(0, 15));
      v = int'($urandom_range(0, 255));
      if (a < 6 && a % 2 == 1) v = 0;
      else if (a < 6) v = v % 16;
      else if (a == 11) v = v % 4;
      else if (a == 12) v = 0;
      wr_reg(a, v);
      idle(int'($urandom_range(10, 250)));
      if (it % 4 == 0) begin
        a = int'($urandom_range(0, 31));
        rd_reg(a, m_regs[a]);
      end
    end

    // Reset asserted in the middle of a write discards it
    wr_reg(2, 8'h33);
    latch(2);
    data_in = 8'h77; bdir = 1'b1; bc1 = 1'b0;
    #2 reset = 1'b1;
    model_init();
    @(posedge clk); #1;
    chk("midwr_master", 32'(master_out), 32'd0);
    chk("midwr_oe", 32'(data_oe), 32'd0);
    data_in = 8'h00; bdir = 1'b0; bc1 = 1'b0;
    reset = 1'b0;
    rd_reg(2, 0);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
